// File: rtl/cpu_pipe_pkg.sv
// Shared types for the CPU pipeline stage registers: payload layout and the
// occupancy encoding used by the elastic EXE->MEM stage.
package cpu_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RN_W   = 5;

  // Packages cannot take parameters, so this is the payload at default widths.
  // Stages with other widths re-declare the same field layout locally.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] rb;
    logic                  wmem;
    logic                  m2reg;
    logic                  wreg;
    logic [DEF_RN_W-1:0]   rn;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a valid bit plus payload. Clear drops the entry and
// zeroes its control bits while leaving the data fields untouched.
module pipe_entry_reg
  import cpu_pipe_pkg::*;
#(
  parameter type entry_t = payload_t
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   load,
  input  logic   clear,
  input  entry_t d,
  output logic   valid,
  output entry_t q
);

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
      q.wmem  <= 1'b0;
      q.m2reg <= 1'b0;
      q.wreg  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/exe_mem_pipe.sv
// EXE->MEM stage register with valid/ready handshake, synchronous flush,
// optional skid entry, forwarding tap and saturating bubble counter.
module exe_mem_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              exe_valid,
  output logic              exe_ready,
  input  logic [DATA_W-1:0] exe_alu_result,
  input  logic [DATA_W-1:0] exe_rb,
  input  logic              exe_wmem,
  input  logic              exe_m2reg,
  input  logic              exe_wreg,
  input  logic [RN_W-1:0]   exe_rn,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_rb,
  output logic              mem_wmem,
  output logic              mem_m2reg,
  output logic              mem_wreg,
  output logic [RN_W-1:0]   mem_rn,
  output logic              fwd_en,
  output logic [RN_W-1:0]   fwd_rn,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rb;
    logic              wmem;
    logic              m2reg;
    logic              wreg;
    logic [RN_W-1:0]   rn;
  } entry_t;

  entry_t      in_d, h_d, h_q, s_q;
  logic        h_valid, s_valid;
  logic        h_load, h_clear, s_load, s_clear, h_from_s;
  logic        accept, pop;
  pipe_state_t state, state_nx;

  always_comb begin
    in_d            = '0;
    in_d.alu_result = exe_alu_result;
    in_d.rb         = exe_rb;
    in_d.wmem       = exe_wmem;
    in_d.m2reg      = exe_m2reg;
    in_d.wreg       = exe_wreg;
    in_d.rn         = exe_rn;
  end

  // With a skid entry, ready is simply "skid empty", which is a flop output.
  assign exe_ready = (SKID != 0) ? ~s_valid : (~h_valid | mem_ready);
  assign accept    = exe_valid & exe_ready & ~flush;
  assign pop       = h_valid & mem_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= EMPTY;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case/if tree can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    h_load   = 1'b0;
    h_clear  = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    h_from_s = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
      h_clear  = 1'b1;
      s_clear  = 1'b1;
    end else if (SKID != 0) begin
      unique case (state)
        EMPTY: if (accept) begin
          state_nx = ONE;
          h_load   = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            h_load = 1'b1;
          end else if (accept) begin
            state_nx = FULL;
            s_load   = 1'b1;
          end else if (pop) begin
            state_nx = EMPTY;
            h_clear  = 1'b1;
          end
        end
        FULL: if (pop) begin
          state_nx = ONE;
          h_load   = 1'b1;
          h_from_s = 1'b1;
          s_clear  = 1'b1;
        end
        default: state_nx = EMPTY;
      endcase
    end else begin
      if (accept) begin
        state_nx = ONE;
        h_load   = 1'b1;
      end else if (pop) begin
        state_nx = EMPTY;
        h_clear  = 1'b1;
      end
    end
  end

  assign h_d = h_from_s ? s_q : in_d;

  pipe_entry_reg #(.entry_t(entry_t)) u_head (
    .clk   (clk),
    .clr   (clr),
    .load  (h_load),
    .clear (h_clear),
    .d     (h_d),
    .valid (h_valid),
    .q     (h_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.entry_t(entry_t)) u_skid (
        .clk   (clk),
        .clr   (clr),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_d),
        .valid (s_valid),
        .q     (s_q)
      );
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign unused_skid_ctl = s_load | s_clear;
      assign s_valid         = 1'b0;
      assign s_q             = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      bubble_cnt <= '0;
    else if (!h_valid && bubble_cnt != {CNT_W{1'b1}})
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  assign mem_valid      = h_valid;
  assign mem_alu_result = h_q.alu_result;
  assign mem_rb         = h_q.rb;
  assign mem_wmem       = h_q.wmem;
  assign mem_m2reg      = h_q.m2reg;
  assign mem_wreg       = h_q.wreg;
  assign mem_rn         = h_q.rn;
  assign fwd_en         = h_valid & h_q.wreg & ~h_q.m2reg;
  assign fwd_rn         = h_q.rn;
  assign fwd_data       = h_q.alu_result;

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Bench for exe_mem_pipe: a skid instance (CNT_W=4) and a no-skid instance,
// each fed by its own producer and checked against a queue-based model.
module tb_exe_mem_pipe;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rb;
    logic        wmem;
    logic        m2reg;
    logic        wreg;
    logic [4:0]  rn;
  } pl_t;

  logic clk = 1'b0;
  logic clr;
  logic ev1, fl1, mr1, ev0, fl0, mr0;
  pl_t  in1, in0;

  logic        u1_ready, u1_valid, u1_wmem, u1_m2reg, u1_wreg, u1_fen;
  logic [31:0] u1_alu, u1_rb, u1_fdata;
  logic [4:0]  u1_rn, u1_frn;
  logic [3:0]  u1_cnt;
  logic        u0_ready, u0_valid, u0_wmem, u0_m2reg, u0_wreg, u0_fen;
  logic [31:0] u0_alu, u0_rb, u0_fdata;
  logic [4:0]  u0_rn, u0_frn;
  logic [15:0] u0_cnt;

  pl_t         mq1[$], mq0[$], src1[$], src0[$];
  logic [3:0]  cnt1;
  logic [15:0] cnt0;
  int          gap;
  int          checks, failures;
  logic [127:0] got, want;

  always #5 clk = ~clk;

  exe_mem_pipe #(.DATA_W(32), .RN_W(5), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .clr(clr), .flush(fl1), .exe_valid(ev1), .exe_ready(u1_ready),
    .exe_alu_result(in1.alu_result), .exe_rb(in1.rb), .exe_wmem(in1.wmem),
    .exe_m2reg(in1.m2reg), .exe_wreg(in1.wreg), .exe_rn(in1.rn),
    .mem_valid(u1_valid), .mem_ready(mr1), .mem_alu_result(u1_alu), .mem_rb(u1_rb),
    .mem_wmem(u1_wmem), .mem_m2reg(u1_m2reg), .mem_wreg(u1_wreg), .mem_rn(u1_rn),
    .fwd_en(u1_fen), .fwd_rn(u1_frn), .fwd_data(u1_fdata), .bubble_cnt(u1_cnt)
  );

  exe_mem_pipe #(.DATA_W(32), .RN_W(5), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .clr(clr), .flush(fl0), .exe_valid(ev0), .exe_ready(u0_ready),
    .exe_alu_result(in0.alu_result), .exe_rb(in0.rb), .exe_wmem(in0.wmem),
    .exe_m2reg(in0.m2reg), .exe_wreg(in0.wreg), .exe_rn(in0.rn),
    .mem_valid(u0_valid), .mem_ready(mr0), .mem_alu_result(u0_alu), .mem_rb(u0_rb),
    .mem_wmem(u0_wmem), .mem_m2reg(u0_m2reg), .mem_wreg(u0_wreg), .mem_rn(u0_rn),
    .fwd_en(u0_fen), .fwd_rn(u0_frn), .fwd_data(u0_fdata), .bubble_cnt(u0_cnt)
  );

  function automatic pl_t rand_pl();
    pl_t p;
    p.alu_result = $urandom;
    p.rb         = $urandom;
    p.wmem       = 1'($urandom_range(1));
    p.m2reg      = 1'($urandom_range(1));
    p.wreg       = 1'($urandom_range(1));
    p.rn         = 5'($urandom_range(31));
    return p;
  endfunction

  function automatic pl_t mk(input logic wm, input logic m2, input logic wr, input logic [4:0] rn);
    pl_t p;
    p.alu_result = $urandom;
    p.rb         = $urandom;
    p.wmem       = wm;
    p.m2reg      = m2;
    p.wreg       = wr;
    p.rn         = rn;
    return p;
  endfunction

  // Observed/expected view: data fields only matter while the entry is valid.
  function automatic logic [127:0] pack(input logic v, input logic [31:0] a, input logic [31:0] b,
                                        input logic wm, input logic m2, input logic wr,
                                        input logic [4:0] rn, input logic [4:0] frn,
                                        input logic [31:0] fd, input logic fen,
                                        input logic [15:0] c, input logic rdy);
    return {v, v ? a : 32'd0, v ? b : 32'd0, wm, m2, wr, v ? rn : 5'd0,
            v ? frn : 5'd0, v ? fd : 32'd0, fen, c, rdy};
  endfunction

  function automatic logic [127:0] obs1();
    return pack(u1_valid, u1_alu, u1_rb, u1_wmem, u1_m2reg, u1_wreg, u1_rn, u1_frn,
                u1_fdata, u1_fen, {12'd0, u1_cnt}, u1_ready);
  endfunction

  function automatic logic [127:0] obs0();
    return pack(u0_valid, u0_alu, u0_rb, u0_wmem, u0_m2reg, u0_wreg, u0_rn, u0_frn,
                u0_fdata, u0_fen, u0_cnt, u0_ready);
  endfunction

  function automatic logic [127:0] exp1();
    pl_t  h = '0;
    logic v = (mq1.size() > 0);
    if (v) h = mq1[0];
    return pack(v, h.alu_result, h.rb, h.wmem, h.m2reg, h.wreg, h.rn, h.rn, h.alu_result,
                v & h.wreg & ~h.m2reg, {12'd0, cnt1}, mq1.size() < 2);
  endfunction

  function automatic logic [127:0] exp0();
    pl_t  h = '0;
    logic v = (mq0.size() > 0);
    if (v) h = mq0[0];
    return pack(v, h.alu_result, h.rb, h.wmem, h.m2reg, h.wreg, h.rn, h.rn, h.alu_result,
                v & h.wreg & ~h.m2reg, cnt0, (mq0.size() == 0) || mr0);
  endfunction

  // One clock: producers present their next item, the model applies the
  // stage rules (capacity 2 with skid, 1 without), then outputs settle.
  task automatic step();
    logic r1, r0, a1, a0, p1, p0;
    ev1 = (src1.size() > 0) && ($urandom_range(99) >= gap);
    ev0 = (src0.size() > 0) && ($urandom_range(99) >= gap);
    in1 = ev1 ? src1[0] : rand_pl();
    in0 = ev0 ? src0[0] : rand_pl();
    r1 = (mq1.size() < 2);
    r0 = (mq0.size() == 0) || mr0;
    a1 = ev1 && r1 && !fl1;
    a0 = ev0 && r0 && !fl0;
    p1 = (mq1.size() > 0) && mr1;
    p0 = (mq0.size() > 0) && mr0;
    if (mq1.size() == 0 && cnt1 != 4'hF) cnt1 = cnt1 + 4'd1;
    if (mq0.size() == 0 && cnt0 != 16'hFFFF) cnt0 = cnt0 + 16'd1;
    @(posedge clk);
    if (fl1) mq1.delete();
    else begin
      if (p1) void'(mq1.pop_front());
      if (a1) mq1.push_back(in1);
    end
    if (fl0) mq0.delete();
    else begin
      if (p0) void'(mq0.pop_front());
      if (a0) mq0.push_back(in0);
    end
    if (a1) void'(src1.pop_front());
    if (a0) void'(src0.pop_front());
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    {ev1, fl1, mr1, ev0, fl0, mr0} = '0;
    in1 = '0; in0 = '0; gap = 0;
    mq1.delete(); mq0.delete(); src1.delete(); src0.delete();
    cnt1 = '0; cnt0 = '0;
    #3;
    got = obs1(); want = exp1(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_skid got=%h want=%h", got, want); end
    got = obs0(); want = exp0(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_noskid got=%h want=%h", got, want); end
    checks++;
    if ({u1_alu, u1_rb, u1_rn, u0_alu, u0_rb, u0_rn} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h %h/%h/%h want=0", u1_alu, u1_rb, u1_rn, u0_alu, u0_rb, u0_rn);
    end
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      src1.push_back(mk(1'b0, 1'b0, 1'b1, 5'(i)));
      src0.push_back(mk(1'b0, 1'b0, 1'b1, 5'(i)));
    end
    mr1 = 1'b1; mr0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL stream_skid cyc=%0d got=%h want=%h", i, got, want); end
      got = obs0(); want = exp0(); checks++;
      if (got !== want) begin failures++; $display("FAIL stream_noskid cyc=%0d got=%h want=%h", i, got, want); end
      if (i <= 4) begin
        checks++;
        if (u1_rn !== 5'(i) || u0_rn !== 5'(i) || u1_fen !== 1'b1 || u0_fen !== 1'b1) begin
          failures++;
          $display("FAIL stream_order cyc=%0d got rn=%0d/%0d fwd=%b/%b want rn=%0d fwd=1", i, u1_rn, u0_rn, u1_fen, u0_fen, i);
        end
      end
      if (i == 1) begin
        checks++;
        if (u1_cnt !== 4'd1 || u0_cnt !== 16'd1) begin
          failures++; $display("FAIL bubble_first got=%0d/%0d want=1", u1_cnt, u0_cnt);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 10; i <= 12; i++) begin
      src1.push_back(mk(1'b0, 1'b0, 1'b1, 5'(i)));
      src0.push_back(mk(1'b0, 1'b0, 1'b1, 5'(i)));
    end
    mr1 = 1'b0; mr0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL stall_skid cyc=%0d got=%h want=%h", i, got, want); end
      got = obs0(); want = exp0(); checks++;
      if (got !== want) begin failures++; $display("FAIL stall_noskid cyc=%0d got=%h want=%h", i, got, want); end
    end
    checks++;
    if (u1_ready !== 1'b0 || u1_rn !== 5'd10 || u0_ready !== 1'b0 || u0_rn !== 5'd10) begin
      failures++;
      $display("FAIL stall_hold got rdy=%b/%b rn=%0d/%0d want rdy=0/0 rn=10/10", u1_ready, u0_ready, u1_rn, u0_rn);
    end
    mr0 = 1'b1; #1;
    checks++;
    if (u0_ready !== 1'b1) begin failures++; $display("FAIL noskid_comb_ready_hi got=%b want=1", u0_ready); end
    mr0 = 1'b0; #1;
    checks++;
    if (u0_ready !== 1'b0) begin failures++; $display("FAIL noskid_comb_ready_lo got=%b want=0", u0_ready); end
    mr1 = 1'b1; mr0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL release_skid cyc=%0d got=%h want=%h", i, got, want); end
      got = obs0(); want = exp0(); checks++;
      if (got !== want) begin failures++; $display("FAIL release_noskid cyc=%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_flush();
    for (int i = 20; i <= 22; i++) begin
      src1.push_back(mk(1'b1, 1'b0, 1'b1, 5'(i)));
      src0.push_back(mk(1'b1, 1'b0, 1'b1, 5'(i)));
    end
    mr1 = 1'b0; mr0 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    fl1 = 1'b1; fl0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (u1_valid !== 1'b0 || u1_wreg !== 1'b0 || u1_wmem !== 1'b0 ||
          u0_valid !== 1'b0 || u0_wreg !== 1'b0 || u0_wmem !== 1'b0) begin
        failures++;
        $display("FAIL flush_squash cyc=%0d got v/wreg/wmem=%b%b%b %b%b%b want 000 000", i,
                 u1_valid, u1_wreg, u1_wmem, u0_valid, u0_wreg, u0_wmem);
      end
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL flush_skid cyc=%0d got=%h want=%h", i, got, want); end
    end
    fl1 = 1'b0; fl0 = 1'b0; mr1 = 1'b1; mr0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL postflush_skid cyc=%0d got=%h want=%h", i, got, want); end
      got = obs0(); want = exp0(); checks++;
      if (got !== want) begin failures++; $display("FAIL postflush_noskid cyc=%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_forwarding();
    logic exp_fen [3];
    exp_fen[0] = 1'b0; exp_fen[1] = 1'b0; exp_fen[2] = 1'b1;
    src1.push_back(mk(1'b0, 1'b1, 1'b1, 5'd7));
    src1.push_back(mk(1'b1, 1'b0, 1'b0, 5'd3));
    src1.push_back(mk(1'b0, 1'b0, 1'b1, 5'd9));
    src0.push_back(mk(1'b0, 1'b1, 1'b1, 5'd7));
    src0.push_back(mk(1'b1, 1'b0, 1'b0, 5'd3));
    src0.push_back(mk(1'b0, 1'b0, 1'b1, 5'd9));
    mr1 = 1'b1; mr0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (u1_fen !== exp_fen[i] || u0_fen !== exp_fen[i]) begin
        failures++;
        $display("FAIL fwd_en op=%0d got=%b/%b want=%b", i, u1_fen, u0_fen, exp_fen[i]);
      end
      got = obs0(); want = exp0(); checks++;
      if (got !== want) begin failures++; $display("FAIL fwd_noskid op=%0d got=%h want=%h", i, got, want); end
    end
    step();
  endtask

  task automatic test_random();
    gap = 25;
    for (int i = 0; i < 400; i++) begin
      if (src1.size() < 3) src1.push_back(rand_pl());
      if (src0.size() < 3) src0.push_back(rand_pl());
      mr1 = ($urandom_range(99) < 65);
      mr0 = ($urandom_range(99) < 65);
      fl1 = ($urandom_range(99) < 4);
      fl0 = ($urandom_range(99) < 4);
      step();
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL random_skid cyc=%0d got=%h want=%h", i, got, want); end
      got = obs0(); want = exp0(); checks++;
      if (got !== want) begin failures++; $display("FAIL random_noskid cyc=%0d got=%h want=%h", i, got, want); end
    end
    gap = 0; fl1 = 1'b0; fl0 = 1'b0;
  endtask

  task automatic test_clr_mid();
    src1.push_back(rand_pl()); src1.push_back(rand_pl());
    src0.push_back(rand_pl()); src0.push_back(rand_pl());
    mr1 = 1'b0; mr0 = 1'b0;
    step(); step();
    clr = 1'b1;
    #1;
    checks++;
    if ({u1_valid, u1_fen, u1_wmem, u1_m2reg, u1_wreg, u1_rn, u1_alu, u1_rb, u1_cnt} !== '0 ||
        {u0_valid, u0_fen, u0_wmem, u0_m2reg, u0_wreg, u0_rn, u0_alu, u0_rb, u0_cnt} !== '0 ||
        u1_ready !== 1'b1 || u0_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_async got v=%b/%b rn=%0d/%0d cnt=%0d/%0d rdy=%b/%b want all 0 rdy=1",
               u1_valid, u0_valid, u1_rn, u0_rn, u1_cnt, u0_cnt, u1_ready, u0_ready);
    end
    mq1.delete(); mq0.delete(); src1.delete(); src0.delete();
    cnt1 = '0; cnt0 = '0;
    #2 clr = 1'b0;
  endtask

  task automatic test_saturate();
    mr1 = 1'b1; mr0 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      got = obs1(); want = exp1(); checks++;
      if (got !== want) begin failures++; $display("FAIL idle_skid cyc=%0d got=%h want=%h", k, got, want); end
      if (k == 14 || k == 20) begin
        checks++;
        if (u1_cnt !== ((k == 14) ? 4'd14 : 4'd15) || u0_cnt !== 16'(k)) begin
          failures++;
          $display("FAIL bubble_sat cyc=%0d got=%0d/%0d want=%0d/%0d", k, u1_cnt, u0_cnt,
                   (k == 14) ? 14 : 15, k);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_forwarding();
    test_random();
    test_clr_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
